// File: rtl/axis_pkt_player.sv
// AXI-Stream packet player: flits are loaded through a ready/valid port into
// an internal buffer, then replayed on an AXI4-Stream master with repeat
// passes, inter-packet gaps and full backpressure.
module axis_pkt_player #(
  parameter int DATA_W    = 64,
  parameter int MAX_FLITS = 32,
  parameter int GAP_W     = 8,
  parameter int ADDR_W    = $clog2(MAX_FLITS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic [DATA_W/8-1:0] ld_keep,
  input  logic                ld_last,
  input  logic                clear,
  input  logic                start,
  input  logic [7:0]          repeat_cnt,
  input  logic [GAP_W-1:0]    gap_cycles,
  output logic [DATA_W-1:0]   M_AXIS_tdata,
  output logic [DATA_W/8-1:0] M_AXIS_tkeep,
  output logic                M_AXIS_tlast,
  output logic                M_AXIS_tvalid,
  input  logic                M_AXIS_tready,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     flit_count,
  output logic [15:0]         pkt_count,
  output logic                overflow
);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(MAX_FLITS);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

  logic [DATA_W-1:0]   mem_data [MAX_FLITS];
  logic [DATA_W/8-1:0] mem_keep [MAX_FLITS];
  logic [MAX_FLITS-1:0] mem_last;

  state_t            state, state_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]        passes;
  logic [GAP_W-1:0]  gap, gcnt;
  logic              full, load, hs, at_end, beat_last, final_beat;

  assign full       = (flit_count == FULL_CNT);
  assign busy       = (state != IDLE);
  assign ld_ready   = !busy && !full;
  assign load       = ld_valid && ld_ready && !clear;
  assign at_end     = ({1'b0, rd_ptr} == (flit_count - CNT_ONE));
  assign beat_last  = mem_last[rd_ptr] || at_end;
  assign final_beat = at_end && (passes == 8'd1);

  // Stream outputs are forced to zero outside STREAM so idle/reset values are clean.
  assign M_AXIS_tvalid = (state == STREAM);
  assign M_AXIS_tdata  = M_AXIS_tvalid ? mem_data[rd_ptr] : '0;
  assign M_AXIS_tkeep  = M_AXIS_tvalid ? mem_keep[rd_ptr] : '0;
  assign M_AXIS_tlast  = M_AXIS_tvalid && beat_last;
  assign hs            = M_AXIS_tvalid && M_AXIS_tready;

  // Flit buffer write port.
  always_ff @(posedge CLK) begin
    if (load) begin
      mem_data[wr_ptr] <= ld_data;
      mem_keep[wr_ptr] <= ld_keep;
      mem_last[wr_ptr] <= ld_last;
    end
  end

  // Buffer occupancy, write pointer and sticky overflow; clear wins over load.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flit_count <= '0;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
    end else if (!busy) begin
      if (clear) begin
        flit_count <= '0;
        wr_ptr     <= '0;
        overflow   <= 1'b0;
      end else if (load) begin
        flit_count <= flit_count + CNT_ONE;
        wr_ptr     <= wr_ptr + PTR_ONE;
      end else if (ld_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Player state register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_d;
  end

  // Player next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start && (flit_count != '0)) state_d = STREAM;
      STREAM:  if (hs) begin
                 if (final_beat)                     state_d = IDLE;
                 else if (beat_last && (gap != '0))  state_d = GAP;
               end
      GAP:     if (gcnt == GAP_ONE) state_d = STREAM;
      default: state_d = IDLE;
    endcase
  end

  // Read pointer, pass/gap counters, packet counter and done pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr    <= '0;
      passes    <= '0;
      gap       <= '0;
      gcnt      <= '0;
      pkt_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (flit_count == '0) begin
            done <= 1'b1;
          end else begin
            passes    <= (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
            gap       <= gap_cycles;
            rd_ptr    <= '0;
            pkt_count <= '0;
          end
        end
        STREAM: if (hs) begin
          if (beat_last) pkt_count <= pkt_count + 16'd1;
          if (final_beat) begin
            done <= 1'b1;
          end else begin
            if (at_end) begin
              rd_ptr <= '0;
              passes <= passes - 8'd1;
            end else begin
              rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (beat_last && (gap != '0)) gcnt <= gap;
          end
        end
        GAP: gcnt <= gcnt - GAP_ONE;
        default: ;
      endcase
    end
  end

endmodule
